// File: rtl/aes_key_sched.sv
// Iterative AES key-schedule engine: one schedule word per cycle, round keys streamed out.
// Optional AES_KEY_SCHED_LAST_KEY_EN adds last_key_o holding the final NK schedule words.
module aes_key_sched #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [32*NK-1:0]  key_i,
  output logic [31:0]       sub_o,
  input  logic [31:0]       sub_i,
  output logic [127:0]      rk_o,
  output logic [3:0]        rk_idx,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              busy,
  output logic              done
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  ,
  output logic [32*NK-1:0]  last_key_o
`endif
);

  localparam int NR    = NK + 6;
  localparam int TOTAL = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE, GEN, DRAIN, FIN} state_t;

  state_t      state, state_n;
  logic [31:0] win [NK];
  logic [31:0] acc [3];
  logic [5:0]  cnt;
  logic [3:0]  imod;
  logic [3:0]  rnd;
  logic        past;
  logic [7:0]  rcon;
  logic [31:0] prev, rot, w_new;
  logic        gen, load, stall, adv, last;

  // word datapath: window tail feeds the S-box port, window head closes the XOR
  always_comb begin
    prev  = win[NK-1];
    rot   = {prev[23:0], prev[31:24]};
    gen   = (state == GEN);
    load  = gen && (cnt[1:0] == 2'b11);
    stall = load && rk_valid && !rk_ready;
    adv   = gen && !stall;
    last  = (cnt == 6'(TOTAL - 1));
    sub_o = '0;
    if (gen)
      sub_o = (imod == 4'd0) ? rot : prev;
    if (!past)
      w_new = win[0];
    else if (imod == 4'd0)
      w_new = win[0] ^ sub_i ^ {rcon, 24'h0};
    else if (NK == 8 && imod == 4'd4)
      w_new = win[0] ^ sub_i;
    else
      w_new = win[0] ^ prev;
  end

  // next-state and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  if (start) state_n = GEN;
      GEN: begin
        busy = 1'b1;
        if (adv && last) state_n = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (rk_valid && rk_ready) state_n = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  // key window, counters, rcon, accumulator and round-key register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < NK; k++) win[k] <= '0;
      for (int k = 0; k < 3; k++) acc[k] <= '0;
      cnt      <= '0;
      imod     <= '0;
      rnd      <= '0;
      past     <= 1'b0;
      rcon     <= '0;
      rk_o     <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        for (int k = 0; k < NK; k++)
          win[k] <= key_i[32*(NK-k)-1 -: 32];
        cnt  <= '0;
        imod <= '0;
        rnd  <= '0;
        past <= 1'b0;
        rcon <= 8'h01;
      end else if (adv) begin
        for (int k = 0; k < NK - 1; k++) win[k] <= win[k+1];
        win[NK-1] <= w_new;
        cnt <= cnt + 6'd1;
        if (imod == 4'(NK - 1)) begin
          imod <= '0;
          past <= 1'b1;
        end else begin
          imod <= imod + 4'd1;
        end
        if (past && imod == 4'd0)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (!load) acc[cnt[1:0]] <= w_new;
      end
      if (adv && load) begin
        rk_o     <= {acc[0], acc[1], acc[2], w_new};
        rk_idx   <= rnd;
        rnd      <= rnd + 4'd1;
        rk_valid <= 1'b1;
      end else if (rk_ready) begin
        rk_valid <= 1'b0;
      end
    end
  end

`ifdef AES_KEY_SCHED_LAST_KEY_EN
  // capture the final NK words as the last one is produced
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_key_o <= '0;
    end else if (adv && last) begin
      for (int k = 1; k < NK; k++)
        last_key_o[32*(NK-k+1)-1 -: 32] <= win[k];
      last_key_o[31:0] <= w_new;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched: NK=4/6/8 instances, scoreboard of expected round keys.
// Expected keys come from a plain FIPS-197 expansion model inside the bench.
module tb_aes_key_sched;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sw(logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, ready;
  logic         start [3];
  logic [255:0] kbuf  [3];
  logic [31:0]  so    [3];
  logic [31:0]  si    [3];
  logic [127:0] rk    [3];
  logic [3:0]   idx   [3];
  logic         vld   [3];
  logic         bsy   [3];
  logic         dn    [3];
`ifdef AES_KEY_SCHED_LAST_KEY_EN
  logic [127:0] lk4;
  logic [191:0] lk6;
  logic [255:0] lk8;
`endif

  assign si[0] = sw(so[0]);
  assign si[1] = sw(so[1]);
  assign si[2] = sw(so[2]);

  aes_key_sched #(.NK(4)) d4 (
    .clk(clk), .nrst(nrst), .start(start[0]), .key_i(kbuf[0][255:128]),
    .sub_o(so[0]), .sub_i(si[0]), .rk_o(rk[0]), .rk_idx(idx[0]),
    .rk_valid(vld[0]), .rk_ready(ready), .busy(bsy[0]), .done(dn[0])
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    , .last_key_o(lk4)
`endif
  );

  aes_key_sched #(.NK(6)) d6 (
    .clk(clk), .nrst(nrst), .start(start[1]), .key_i(kbuf[1][255:64]),
    .sub_o(so[1]), .sub_i(si[1]), .rk_o(rk[1]), .rk_idx(idx[1]),
    .rk_valid(vld[1]), .rk_ready(ready), .busy(bsy[1]), .done(dn[1])
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    , .last_key_o(lk6)
`endif
  );

  aes_key_sched #(.NK(8)) d8 (
    .clk(clk), .nrst(nrst), .start(start[2]), .key_i(kbuf[2]),
    .sub_o(so[2]), .sub_i(si[2]), .rk_o(rk[2]), .rk_idx(idx[2]),
    .rk_valid(vld[2]), .rk_ready(ready), .busy(bsy[2]), .done(dn[2])
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    , .last_key_o(lk8)
`endif
  );

  int           n_assert = 0;
  int           n_fail   = 0;
  logic [31:0]  mw  [60];
  logic [127:0] got [3][15];
  logic [127:0] eq [$];
  logic [3:0]   ei [$];

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expand(int nk, logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        mw[i] = key[255-32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk == 8 && i % nk == 4) begin
          t = sw(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endfunction

  task automatic run(input int s, input int stall_r, input int stall_n, input bit glitch);
    int           nk, nr, c, stl, first, lastc, dcyc;
    logic [127:0] held;
    logic [31:0]  hsub;
    logic [255:0] orig;
    nk    = 4 + 2 * s;
    nr    = nk + 6;
    stl   = 0;
    first = -1;
    lastc = -1;
    dcyc  = -1;
    held  = '0;
    hsub  = '0;
    orig  = kbuf[s];
    expand(nk, orig);
    for (int r = 0; r <= nr; r++) begin
      eq.push_back({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
      ei.push_back(4'(r));
    end
    start[s] = 1'b1;
    tick();
    start[s] = 1'b0;
    c = 1;
    chk("busy_c1", 256'(bsy[s]), 256'(1));
    if (glitch) kbuf[s] = ~orig;
    while (c < 300) begin
      ready    = 1'b1;
      start[s] = glitch && c == 10;
      if (vld[s] && idx[s] == 4'(stall_r) && stl < stall_n) begin
        if (stl == 0) held = rk[s];
        else chk("stall_rk", 256'(rk[s]), 256'(held));
        if (stl == 3) hsub = so[s];
        if (stl >= 4) chk("stall_sub", 256'(so[s]), 256'(hsub));
        ready = 1'b0;
        stl++;
      end
      if (s == 2 && c == 9)
        chk("sub_rot_i8", 256'(so[s]), 256'({mw[7][23:0], mw[7][31:24]}));
      if (s == 2 && c == 13)
        chk("sub_norot_i12", 256'(so[s]), 256'(mw[11]));
      if (vld[s] && ready) begin
        if (first < 0) first = c;
        if (eq.size() == 0) begin
          chki("extra_key", 1, 0);
        end else begin
          chk("rk", 256'(rk[s]), 256'(eq.pop_front()));
          chk("rk_idx", 256'(idx[s]), 256'(ei.pop_front()));
          got[s][idx[s]] = rk[s];
          if (int'(idx[s]) == nr) lastc = c;
        end
      end
      if (dn[s]) begin
        dcyc = c;
        break;
      end
      tick();
      c++;
    end
    start[s] = 1'b0;
    ready    = 1'b1;
    kbuf[s]  = orig;
    chki("done_seen", int'(dcyc >= 0), 1);
    chki("sb_empty", eq.size(), 0);
    chk("busy_at_done", 256'(bsy[s]), 256'(0));
    if (stall_n == 0) begin
      chki("first_valid_cycle", first, 5);
      chki("last_valid_cycle", lastc, 5 + 4 * nr);
    end
    chki("done_cycle", dcyc, 4 * nr + 6 + (stall_n > 3 ? stall_n - 3 : 0));
    tick();
    chk("done_pulse", 256'(dn[s]), 256'(0));
    eq.delete();
    ei.delete();
  endtask

  task automatic reset_mid();
    int found;
    found    = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (vld[0] && idx[0] == 4'd5) begin
        found = 1;
        break;
      end
      tick();
    end
    chki("reach_round5", found, 1);
    nrst = 1'b0;
    tick();
    chk("rst_valid", 256'(vld[0]), 256'(0));
    chk("rst_busy", 256'(bsy[0]), 256'(0));
    chk("rst_idx", 256'(idx[0]), 256'(0));
    chk("rst_rk", 256'(rk[0]), 256'(0));
    nrst = 1'b1;
    tick();
  endtask

  initial begin
    logic [255:0] lexp;
    nrst    = 1'b0;
    ready   = 1'b1;
    start   = '{default: 1'b0};
    kbuf[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kbuf[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    kbuf[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("reset_valid", 256'(vld[s]), 256'(0));
      chk("reset_busy", 256'(bsy[s] | dn[s]), 256'(0));
      chk("reset_idx_rk", 256'({idx[s], rk[s]}), 256'(0));
      chk("reset_sub", 256'(so[s]), 256'(0));
    end
    nrst = 1'b1;
    tick();

    run(0, 99, 0, 1'b0);
    chk("kat4_r0", 256'(got[0][0]), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    chk("kat4_r1", 256'(got[0][1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
    chk("kat4_r10", 256'(got[0][10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    run(1, 99, 0, 1'b0);
    chk("kat6_r12", 256'(got[1][12]), 256'(128'he98ba06f448c773c8ecc720401002202));

    run(2, 99, 0, 1'b0);
    chk("kat8_r14", 256'(got[2][14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));
`ifdef AES_KEY_SCHED_LAST_KEY_EN
    lexp = '0;
    for (int k = 0; k < 8; k++) lexp[255-32*k -: 32] = mw[52+k];
    chk("last_key8", lk8, lexp);
    chk("last_key8_tail", 256'(lk8[31:0]), 256'(32'h706c631e));
`else
    lexp = '0;
`endif

    run(0, 3, 10, 1'b0);
    chk("stall_kat_r10", 256'(got[0][10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    run(0, 2, 3, 1'b0);
    run(0, 99, 0, 1'b1);
    chk("glitch_kat_r1", 256'(got[0][1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));

    reset_mid();
    run(0, 99, 0, 1'b0);
    chk("post_rst_r0", 256'(got[0][0]), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
